// File: rtl/sitcpxg_pkg.sv
// Shared definitions for the SiTCP-XG receive-buffer reader: FSM encoding,
// buffer geometry defaults and byte-lane helpers.
package sitcpxg_pkg;

   localparam int ADDR_W_DEF     = 13;
   localparam int RX_SIZE_MARGIN = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_OUT  = 2'd2,
      ST_CLR  = 2'd3
   } rx_state_t;

   // Bytes covered by a write, counted from lane offset 0 through the lowest enabled lane.
   function automatic logic [3:0] wenb_span(input logic [7:0] wenb);
      logic [3:0] span;
      span = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         if (wenb[i]) begin
            span = 4'(8 - i);
         end
      end
      return span;
   endfunction

   // Big-endian byte select: offset 0 is bits [63:56].
   function automatic logic [7:0] byte_sel(input logic [63:0] word, input logic [2:0] off);
      logic [63:0] sh;
      sh = word >> {3'd7 - off, 3'b000};
      return sh[7:0];
   endfunction

endpackage

// File: rtl/sitcpxg_rx_bram.sv
// Simple dual-port 64-bit RAM with eight byte-lane write enables and a
// one-cycle registered read; a same-cycle collision returns the old word.
module sitcpxg_rx_bram #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic [7:0]    we,
   input  logic [AW-1:0] waddr,
   input  logic [63:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [63:0]   rdata
);

   logic [63:0] mem [2**AW];

   // Byte-lane write port.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (we[i]) begin
            mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Registered read port.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/sitcpxg_rx_buf_reader.sv
// Receive buffer written by SiTCP-XG and drained as a ready/valid byte stream,
// with ring pointers and a handshaked buffer-clear sequence.
module sitcpxg_rx_buf_reader
   import sitcpxg_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic        XGMII_CLOCK,
   input  logic        RSTn,
   output logic [15:0] USER_RX_SIZE,
   input  logic        USER_RX_CLR_ENB,
   output logic        USER_RX_CLR_REQ,
   output logic [15:0] USER_RX_RADR,
   input  logic [15:0] USER_RX_WADR,
   input  logic [7:0]  USER_RX_WENB,
   input  logic [63:0] USER_RX_WDAT,
   output logic [7:0]  M_DATA,
   output logic        M_VALID,
   input  logic        M_READY
);

   localparam int WA = ADDR_W - 3;

   rx_state_t         state_r;
   logic [ADDR_W-1:0] rptr_r;
   logic [ADDR_W-1:0] wptr_r;
   logic [ADDR_W-1:0] snap_r;
   logic [63:0]       hold_r;
   logic              m_valid_r;
   logic [7:0]        m_data_r;
   logic              clr_req_r;
   logic [15:0]       radr_r;

   logic              wr_s;
   logic [7:0]        bram_we_s;
   logic [ADDR_W-1:0] wptr_new_s;
   logic [ADDR_W-1:0] avail_s;
   logic [ADDR_W-1:0] rptr_nxt_s;
   logic [ADDR_W-1:0] avail_nxt_s;
   logic              consume_s;
   logic              stay_s;
   logic              rd_en_s;
   logic [WA-1:0]     rd_addr_s;
   logic [63:0]       rd_data_s;
   logic [15:0]       wadr_unused_s;

   assign USER_RX_SIZE    = 16'(2**ADDR_W - RX_SIZE_MARGIN);
   assign USER_RX_CLR_REQ = clr_req_r;
   assign USER_RX_RADR    = radr_r;
   assign M_DATA          = m_data_r;
   assign M_VALID         = m_valid_r;
   assign wadr_unused_s   = USER_RX_WADR;

   // Pointer arithmetic and read-issue decisions. snap_r is the write pointer
   // at the moment the held word was read, so bytes at or beyond it need a re-read.
   always_comb begin
      wr_s        = (USER_RX_WENB != 8'h00) && (state_r != ST_CLR);
      bram_we_s   = wr_s ? USER_RX_WENB : 8'h00;
      wptr_new_s  = {USER_RX_WADR[ADDR_W-1:3], 3'b000} + ADDR_W'(wenb_span(USER_RX_WENB));
      avail_s     = wptr_r - rptr_r;
      rptr_nxt_s  = rptr_r + ADDR_W'(1);
      avail_nxt_s = wptr_r - rptr_nxt_s;
      consume_s   = (state_r == ST_OUT) && m_valid_r && M_READY;
      stay_s      = (rptr_r[2:0] != 3'd7) && (rptr_nxt_s != snap_r);
      rd_en_s     = 1'b0;
      rd_addr_s   = rptr_r[ADDR_W-1:3];
      if ((state_r == ST_IDLE) && (avail_s != '0)) begin
         rd_en_s = 1'b1;
      end else if (consume_s && !stay_s && (avail_nxt_s != '0)) begin
         rd_en_s   = 1'b1;
         rd_addr_s = rptr_nxt_s[ADDR_W-1:3];
      end else begin
         rd_en_s = 1'b0;
      end
   end

   sitcpxg_rx_bram #(.AW(WA)) u_bram (
      .clk   (XGMII_CLOCK),
      .we    (bram_we_s),
      .waddr (USER_RX_WADR[ADDR_W-1:3]),
      .wdata (USER_RX_WDAT),
      .re    (rd_en_s),
      .raddr (rd_addr_s),
      .rdata (rd_data_s)
   );

   // Reader FSM with pointers and registered stream/clear outputs.
   always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
      if (!RSTn) begin
         state_r   <= ST_IDLE;
         rptr_r    <= '0;
         wptr_r    <= '0;
         snap_r    <= '0;
         hold_r    <= 64'd0;
         m_valid_r <= 1'b0;
         m_data_r  <= 8'd0;
         clr_req_r <= 1'b0;
         radr_r    <= 16'd0;
      end else begin
         clr_req_r <= 1'b0;
         if (state_r == ST_CLR) begin
            wptr_r <= '0;
         end else if (wr_s) begin
            wptr_r <= wptr_new_s;
         end
         if (rd_en_s) begin
            snap_r <= wptr_r;
         end
         case (state_r)
            ST_IDLE: begin
               m_valid_r <= 1'b0;
               if (avail_s != '0) begin
                  state_r <= ST_RD;
               end else if (USER_RX_CLR_ENB && !m_valid_r && (USER_RX_WENB == 8'h00)) begin
                  state_r   <= ST_CLR;
                  clr_req_r <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RD: begin
               hold_r    <= rd_data_s;
               m_data_r  <= byte_sel(rd_data_s, rptr_r[2:0]);
               m_valid_r <= 1'b1;
               state_r   <= ST_OUT;
            end
            ST_OUT: begin
               if (consume_s) begin
                  rptr_r <= rptr_nxt_s;
                  radr_r <= 16'(rptr_nxt_s);
                  if (stay_s) begin
                     m_data_r <= byte_sel(hold_r, rptr_nxt_s[2:0]);
                  end else if (avail_nxt_s != '0) begin
                     m_valid_r <= 1'b0;
                     state_r   <= ST_RD;
                  end else begin
                     m_valid_r <= 1'b0;
                     state_r   <= ST_IDLE;
                  end
               end
            end
            ST_CLR: begin
               rptr_r    <= '0;
               radr_r    <= 16'd0;
               m_valid_r <= 1'b0;
               state_r   <= ST_IDLE;
            end
            default: begin
               m_valid_r <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
